// File: rtl/ad9708_pkg.sv
// Shared constants for the AD9708 self-test waveform source.
// Wave selects, FSM states, default midscale code, tkeep helper.
package ad9708_pkg;

  localparam logic [1:0] WAVE_RAMP  = 2'd0;
  localparam logic [1:0] WAVE_TRI   = 2'd1;
  localparam logic [1:0] WAVE_SQR   = 2'd2;
  localparam logic [1:0] WAVE_CONST = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] MIDSCALE_DEF = 8'h80;

  // Byte enables of the final word; first sample sits in bit 3.
  function automatic logic [3:0] keep_of(input logic [1:0] r);
    logic [3:0] k;
    unique case (r)
      2'd0: k = 4'hF;
      2'd1: k = 4'h8;
      2'd2: k = 4'hC;
      default: k = 4'hE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ad9708_wave_lut.sv
// Phase byte to 8-bit straight-binary sample, one lane.
// Ports: phase_byte, wave_sel in; sample out (combinational).
module ad9708_wave_lut
  import ad9708_pkg::*;
#(
  parameter logic [7:0] MIDSCALE = MIDSCALE_DEF
) (
  input  logic [7:0] phase_byte,
  input  logic [1:0] wave_sel,
  output logic [7:0] sample
);

  logic [7:0] tri_v;

  // Fold the upper half back down to form a triangle.
  assign tri_v = phase_byte[7] ?
    {~phase_byte[6:0], 1'b0} :
    { phase_byte[6:0], 1'b0};

  always_comb begin
    sample = MIDSCALE;
    unique case (1'b1)
      (wave_sel == WAVE_RAMP): sample = phase_byte;
      (wave_sel == WAVE_TRI):  sample = tri_v;
      (wave_sel == WAVE_SQR):
        sample = phase_byte[7] ? 8'hFF : 8'h00;
      default: sample = MIDSCALE;
    endcase
  end

endmodule

// File: rtl/ad9708_wave_gen.sv
// AXI-Stream waveform burst source, four 8-bit samples per word.
// Ports: DMA_CLK/DMA_RST_N, gen_* control, M_AXIS_* master stream.
module ad9708_wave_gen
  import ad9708_pkg::*;
#(
  parameter int         PHASE_W  = 16,
  parameter logic [7:0] MIDSCALE = MIDSCALE_DEF
) (
  input  logic               DMA_CLK,
  input  logic               DMA_RST_N,
  input  logic               gen_start,
  input  logic [31:0]        gen_len,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] phase_step,
  output logic               gen_busy,
  output logic               gen_done,
  output logic [31:0]        M_AXIS_tdata,
  output logic [3:0]         M_AXIS_tkeep,
  output logic               M_AXIS_tlast,
  output logic               M_AXIS_tvalid,
  input  logic               M_AXIS_tready
);

  logic               start_q;
  logic               rise;
  logic [1:0]         state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step_r;
  logic [1:0]         sel_r;
  logic [1:0]         rem_r;
  logic [30:0]        cnt;
  logic [30:0]        words;
  logic [PHASE_W-1:0] lp [4];
  logic [7:0]         smp [4];
  logic [PHASE_W-1:0] phase_nxt;
  logic               last_w;
  logic [3:0]         keep_w;
  logic [31:0]        data_w;
  logic               load_en;
  logic               fin_hs;

  assign rise  = gen_start & ~start_q;
  assign words = {1'b0, gen_len[31:2]}
               + {30'd0, |gen_len[1:0]};

  always_comb begin
    lp[0] = phase;
    lp[1] = phase + step_r;
    lp[2] = lp[1] + step_r;
    lp[3] = lp[2] + step_r;
  end
  assign phase_nxt = lp[3] + step_r;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    ad9708_wave_lut #(.MIDSCALE(MIDSCALE)) u_lut (
      .phase_byte(lp[k][PHASE_W-1 -: 8]),
      .wave_sel  (sel_r),
      .sample    (smp[k])
    );
  end

  // cnt holds words still to load, including the one being loaded.
  assign last_w = (cnt == 31'd1);
  assign keep_w = last_w ? keep_of(rem_r) : 4'hF;
  assign data_w = {smp[0], smp[1], smp[2], smp[3]}
                & {{8{keep_w[3]}}, {8{keep_w[2]}},
                   {8{keep_w[1]}}, {8{keep_w[0]}}};

  assign fin_hs  = (state == S_SEND) & M_AXIS_tready
                 & M_AXIS_tlast;
  assign load_en = (state == S_LOAD)
                 | ((state == S_SEND) & M_AXIS_tready
                    & ~M_AXIS_tlast);

  always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
    if (!DMA_RST_N) begin
      start_q       <= 1'b0;
      state         <= S_IDLE;
      phase         <= '0;
      step_r        <= '0;
      sel_r         <= '0;
      rem_r         <= '0;
      cnt           <= '0;
      gen_busy      <= 1'b0;
      gen_done      <= 1'b0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tkeep  <= '0;
      M_AXIS_tlast  <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
    end else begin
      start_q  <= gen_start;
      gen_done <= 1'b0;
      if (load_en) begin
        M_AXIS_tdata  <= data_w;
        M_AXIS_tkeep  <= keep_w;
        M_AXIS_tlast  <= last_w;
        M_AXIS_tvalid <= 1'b1;
        phase         <= phase_nxt;
        cnt           <= cnt - 31'd1;
      end
      unique case (1'b1)
        (state == S_IDLE): begin
          if (rise) begin
            step_r   <= phase_step;
            sel_r    <= wave_sel;
            rem_r    <= gen_len[1:0];
            cnt      <= words;
            phase    <= '0;
            gen_busy <= 1'b1;
            state    <= (gen_len == 32'd0) ?
                        S_DONE : S_LOAD;
          end
        end
        (state == S_LOAD): state <= S_SEND;
        (state == S_SEND): begin
          if (fin_hs) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            state         <= S_DONE;
          end
        end
        default: begin
          gen_done <= 1'b1;
          gen_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9708_wave_gen.sv
// Randomized self-checking bench for ad9708_wave_gen.
// Reference model builds expected beats from sample arithmetic.
module tb_ad9708_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_start = 1'b0;
  logic [31:0] gen_len = '0;
  logic [1:0]  wave_sel = '0;
  logic [15:0] phase_step = '0;
  logic        gen_busy, gen_done;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid;
  logic        tready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] first_data;

  always #5 clk = ~clk;

  ad9708_wave_gen dut (
    .DMA_CLK      (clk),
    .DMA_RST_N    (rst_n),
    .gen_start    (gen_start),
    .gen_len      (gen_len),
    .wave_sel     (wave_sel),
    .phase_step   (phase_step),
    .gen_busy     (gen_busy),
    .gen_done     (gen_done),
    .M_AXIS_tdata (tdata),
    .M_AXIS_tkeep (tkeep),
    .M_AXIS_tlast (tlast),
    .M_AXIS_tvalid(tvalid),
    .M_AXIS_tready(tready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int model_sample(input int sel,
                                      input int b);
    case (sel)
      0: return b;
      1: return (b < 128) ? 2 * b : 2 * (255 - b);
      2: return (b >= 128) ? 255 : 0;
      default: return 128;
    endcase
  endfunction

  // rmode: 0 always ready, 1 toggling 1010, 2 random.
  // restart_at: cycle to pulse a second start (0 = none).
  // abort_after: assert reset after this many beats (0 = none).
  task automatic run_burst(input int sel, input int step,
                           input int len, input int rmode,
                           input int restart_at,
                           input int abort_after);
    logic [31:0] ed [$];
    logic [3:0]  ek [$];
    logic        el [$];
    int nw, bi, cyc, budget, done_cnt, post, busy_cyc;
    int first_cyc;
    logic stall;
    logic [31:0] hd;
    logic [3:0]  hk;
    logic        hl;
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w;
      logic [3:0]  kp;
      w = 0;
      kp = 0;
      for (int k = 0; k < 4; k++) begin
        int n, ph, s;
        n  = 4 * i + k;
        ph = (n * step) % 65536;
        s  = (n < len) ? model_sample(sel, ph / 256) : 0;
        w  = w | (32'(s) << (24 - 8 * k));
        if (n < len) kp = kp | (4'h8 >> k);
      end
      ed.push_back(w);
      ek.push_back(kp);
      el.push_back(i == nw - 1);
    end
    wave_sel   = 2'(sel);
    phase_step = 16'(step);
    gen_len    = 32'(len);
    gen_start  = 1'b1;
    bi = 0; cyc = 0; done_cnt = 0; post = 0;
    busy_cyc = 0; first_cyc = -1; stall = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    budget = nw * 10 + 40;
    while (cyc < budget && post < 5) begin
      @(posedge clk);
      #1;
      if (abort_after > 0 && bi == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_busy",   32'(gen_busy), 0);
        chk("rst_tlast",  32'(tlast), 0);
        chk("rst_done",   32'(gen_done), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_done", 32'(gen_done | tvalid), 0);
        rst_n = 1'b1;
        tready = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      gen_start = (restart_at > 0 && cyc == restart_at);
      case (rmode)
        0: tready = 1'b1;
        1: tready = (cyc % 2 == 1);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      if (gen_busy) busy_cyc++;
      if (stall) begin
        chk("hold_valid", 32'(tvalid), 1);
        chk("hold_data", tdata, hd);
        chk("hold_keep", 32'(tkeep), 32'(hk));
        chk("hold_last", 32'(tlast), 32'(hl));
      end
      stall = 1'b0;
      if (tvalid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_data = tdata;
          chk("busy_at_valid", 32'(gen_busy), 1);
          if (restart_at == 0 && rmode == 0)
            chk("start_latency", 32'(cyc), 2);
        end
        if (tready) begin
          if (bi < nw) begin
            chk("beat_data", tdata, ed[bi]);
            chk("beat_keep", 32'(tkeep), 32'(ek[bi]));
            chk("beat_last", 32'(tlast), 32'(el[bi]));
            if (rmode == 0)
              chk("b2b_cycle", 32'(cyc),
                  32'(first_cyc + bi));
          end else begin
            chk("extra_beat", 32'(bi), 32'(nw));
          end
          bi++;
        end else begin
          stall = 1'b1;
          hd = tdata; hk = tkeep; hl = tlast;
        end
      end
      if (gen_done) begin
        done_cnt++;
        chk("done_after_beats", 32'(bi), 32'(nw));
      end
      if (done_cnt > 0) post++;
    end
    gen_start = 1'b0;
    tready = 1'b0;
    chk("beat_count", 32'(bi), 32'(nw));
    chk("done_count", 32'(done_cnt), 1);
    chk("busy_end", 32'(gen_busy), 0);
    if (len == 0)
      chk("busy_len0", 32'(busy_cyc), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tvalid", 32'(tvalid), 0);
    chk("reset_tlast", 32'(tlast), 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_tkeep", 32'(tkeep), 0);
    chk("reset_busy", 32'(gen_busy), 0);
    chk("reset_done", 32'(gen_done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_burst(0, 16'h0100, 8, 0, 0, 0);
    chk("tp_ramp_w0", first_data, 32'h00010203);
    run_burst(0, 16'h0100, 6, 0, 0, 0);
    run_burst(1, 16'h4000, 4, 0, 0, 0);
    chk("tp_tri_w0", first_data, 32'h0080FE7E);
    run_burst(2, 16'h4000, 8, 1, 0, 0);
    chk("tp_sqr_w0", first_data, 32'h0000FFFF);
    run_burst(3, 16'h1234, 7, 0, 0, 0);
    run_burst(0, 0, 0, 0, 0, 0);
    run_burst(1, 16'h0040, 1024, 0, 50, 0);
    run_burst(0, 16'h0100, 40, 0, 0, 3);
    run_burst(0, 16'h0100, 8, 0, 0, 0);
    chk("tp_after_rst_w0", first_data, 32'h00010203);

    for (int t = 0; t < 10; t++)
      run_burst($urandom_range(0, 3),
                $urandom_range(0, 65535),
                $urandom_range(0, 41), 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
